// File: rtl/neighbourhood_fetch_ctrl_pkg.sv
// Shared sample width, frame geometry defaults and FSM encodings for the
// JPEG-LS neighbourhood fetch controller.
`ifndef PIXEL_LENGTH
`define PIXEL_LENGTH 8
`endif

package neighbourhood_fetch_ctrl_pkg;

  localparam int PIXEL_LENGTH   = `PIXEL_LENGTH;
  localparam int IMG_WIDTH_DEF  = 64;
  localparam int IMG_HEIGHT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_buffer_1row.sv
// One-row sample store: single write port at k, combinational reads at
// k-1, k and k+1, with out-of-range reads returning zero.
module line_buffer_1row
  import neighbourhood_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = IMG_WIDTH_DEF,
  parameter int PW    = PIXEL_LENGTH,
  parameter int AW    = cnt_width(IMG_WIDTH_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [PW-1:0] wr_data,
  output logic [PW-1:0] rd_left,
  output logic [PW-1:0] rd_mid,
  output logic [PW-1:0] rd_right
);

  logic [PW-1:0] mem_r [WIDTH];

  // Storage: async reset, synchronous clear on frame arm, single write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) mem_r[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < WIDTH; i++) mem_r[i] <= '0;
    end else if (wr_en) begin
      mem_r[addr] <= wr_data;
    end
  end

  // Read ports see the pre-write contents of the current cycle.
  always_comb begin
    rd_left  = '0;
    rd_mid   = mem_r[addr];
    rd_right = '0;
    if (addr != '0) begin
      rd_left = mem_r[addr - AW'(1)];
    end else begin
      rd_left = '0;
    end
    if (32'(addr) < WIDTH - 1) begin
      rd_right = mem_r[addr + AW'(1)];
    end else begin
      rd_right = '0;
    end
  end

endmodule

// File: rtl/neighbourhood_fetch_ctrl.sv
// JPEG-LS front-end sequencer: accepts one raster frame, builds the causal
// template (a, b, c, d, x) per pixel and strobes it into stage 1.
module neighbourhood_fetch_ctrl
  import neighbourhood_fetch_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic [PIXEL_LENGTH-1:0] pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic [PIXEL_LENGTH-1:0] a_out,
  output logic [PIXEL_LENGTH-1:0] b_out,
  output logic [PIXEL_LENGTH-1:0] c_out,
  output logic [PIXEL_LENGTH-1:0] d_out,
  output logic [PIXEL_LENGTH-1:0] x_out,
  output logic                    eol_out,
  output logic                    eof_out,
  output logic                    start_enc,
  output logic                    busy
);

  localparam int PW = PIXEL_LENGTH;
  localparam int CW = cnt_width(IMG_WIDTH);
  localparam int RW = cnt_width(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  state_t        state_r;
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [PW-1:0] b_hist_r;
  logic [PW-1:0] c_row_r;

  logic          accept_s;
  logic          arm_s;
  logic [PW-1:0] rd_left_s, rd_mid_s, rd_right_s;
  logic [PW-1:0] a_s, b_s, c_s, d_s;

  assign accept_s = pix_valid & pix_ready;
  assign arm_s    = (state_r == ST_IDLE) & frame_start;

  line_buffer_1row #(
    .WIDTH (IMG_WIDTH),
    .PW    (PW),
    .AW    (CW)
  ) u_line_buffer (
    .clk      (clk),
    .reset    (reset),
    .clear    (arm_s),
    .wr_en    (accept_s),
    .addr     (col_r),
    .wr_data  (pix_in),
    .rd_left  (rd_left_s),
    .rd_mid   (rd_mid_s),
    .rd_right (rd_right_s)
  );

  // Edge rules. prev[k-1] is already overwritten with x(r,k-1), so it serves
  // as a; the old prev[k-1] (c) is the b captured for the previous pixel.
  always_comb begin
    b_s = (row_r != '0) ? rd_mid_s : '0;
    a_s = (col_r != '0) ? rd_left_s : b_s;
    if (col_r != '0) begin
      c_s = b_hist_r;
    end else if (32'(row_r) >= 32'd2) begin
      c_s = c_row_r;
    end else begin
      c_s = '0;
    end
    if (row_r == '0) begin
      d_s = '0;
    end else if (col_r == COL_LAST) begin
      d_s = b_s;
    end else begin
      d_s = rd_right_s;
    end
  end

  // FSM, raster counters, template history and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      col_r     <= '0;
      row_r     <= '0;
      b_hist_r  <= '0;
      c_row_r   <= '0;
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      start_enc <= 1'b0;
      eol_out   <= 1'b0;
      eof_out   <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      c_out     <= '0;
      d_out     <= '0;
      x_out     <= '0;
    end else begin
      start_enc <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (frame_start) begin
            state_r   <= ST_RUN;
            pix_ready <= 1'b1;
            busy      <= 1'b1;
            col_r     <= '0;
            row_r     <= '0;
            b_hist_r  <= '0;
            c_row_r   <= '0;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            a_out     <= a_s;
            b_out     <= b_s;
            c_out     <= c_s;
            d_out     <= d_s;
            x_out     <= pix_in;
            eol_out   <= (col_r == COL_LAST);
            eof_out   <= (col_r == COL_LAST) && (row_r == ROW_LAST);
            start_enc <= 1'b1;
            b_hist_r  <= b_s;
            if (col_r == '0) c_row_r <= rd_mid_s;
            if (col_r == COL_LAST) begin
              col_r <= '0;
              if (row_r == ROW_LAST) begin
                row_r     <= '0;
                state_r   <= ST_DONE;
                pix_ready <= 1'b0;
                busy      <= 1'b0;
              end else begin
                row_r <= row_r + RW'(1);
              end
            end else begin
              col_r <= col_r + CW'(1);
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          pix_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neighbourhood_fetch_ctrl.sv
// Directed bench for neighbourhood_fetch_ctrl on a 4x3 frame of samples 1..12.
module tb_neighbourhood_fetch_ctrl;
  import neighbourhood_fetch_ctrl_pkg::*;

  localparam int PW = PIXEL_LENGTH;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [PW-1:0] pix_in = '0;
  logic          pix_ready, eol_out, eof_out, start_enc, busy;
  logic [PW-1:0] a_out, b_out, c_out, d_out, x_out;

  int checks = 0;
  int errors = 0;

  // Hand-derived (a, b, c, d) for pixels 1..12 of the 4x3 frame.
  int exp_t [12][4] = '{
    '{0, 0, 0, 0}, '{1, 0, 0, 0}, '{2, 0, 0, 0}, '{3, 0, 0, 0},
    '{1, 1, 0, 2}, '{5, 2, 1, 3}, '{6, 3, 2, 4}, '{7, 4, 3, 4},
    '{5, 5, 1, 6}, '{9, 6, 5, 7}, '{10, 7, 6, 8}, '{11, 8, 7, 8}
  };

  neighbourhood_fetch_ctrl #(
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .a_out       (a_out),
    .b_out       (b_out),
    .c_out       (c_out),
    .d_out       (d_out),
    .x_out       (x_out),
    .eol_out     (eol_out),
    .eof_out     (eof_out),
    .start_enc   (start_enc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {a_out, b_out, c_out, d_out, x_out, eol_out, eof_out, start_enc, busy, pix_ready}, 64'd0);
  endtask

  // Arms a frame and feeds pixels 1..last_px, checking every template.
  task automatic run_frame(input bit gap, input bit fs_mid, input int last_px);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("arm_ready", pix_ready, 1);
    chk("arm_busy", busy, 1);
    chk("arm_no_strobe", start_enc, 0);
    for (int p = 1; p <= last_px; p++) begin
      if (gap && p == 3) begin
        pix_valid = 1'b0;
        step();
        chk("gap_strobe", start_enc, 0);
        chk("gap_hold_x", x_out, 2);
        chk("gap_hold_a", a_out, 1);
        chk("gap_ready", pix_ready, 1);
      end
      pix_valid   = 1'b1;
      pix_in      = PW'(p);
      frame_start = (fs_mid && p == 7);
      step();
      frame_start = 1'b0;
      chk($sformatf("px%0d_strobe", p), start_enc, 1);
      chk($sformatf("px%0d_a", p), a_out, exp_t[p-1][0]);
      chk($sformatf("px%0d_b", p), b_out, exp_t[p-1][1]);
      chk($sformatf("px%0d_c", p), c_out, exp_t[p-1][2]);
      chk($sformatf("px%0d_d", p), d_out, exp_t[p-1][3]);
      chk($sformatf("px%0d_x", p), x_out, p);
      chk($sformatf("px%0d_eol", p), eol_out, (p % 4 == 0));
      chk($sformatf("px%0d_eof", p), eof_out, (p == 12));
    end
    pix_valid = 1'b0;
    if (last_px == 12) begin
      chk("done_ready", pix_ready, 0);
      chk("done_busy", busy, 0);
      step();
      chk("idle_strobe", start_enc, 0);
      chk("idle_ready", pix_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_hold_x", x_out, 12);
      chk("idle_hold_eof", eof_out, 1);
    end
  endtask

  initial begin
    repeat (2) step();
    chk_all_zero("reset_outputs");
    reset = 1'b1;
    step();
    chk_all_zero("post_reset_idle");

    // Plain frame, then a frame with a valid gap between pixels 2 and 3.
    run_frame(1'b0, 1'b0, 12);
    run_frame(1'b1, 1'b0, 12);

    // Abandon a frame after pixel 6 with an asynchronous reset.
    run_frame(1'b0, 1'b0, 6);
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset_outputs");
    step();
    chk_all_zero("held_reset_outputs");
    reset = 1'b1;
    step();
    run_frame(1'b0, 1'b0, 12);

    // frame_start pulsed during RUN must be ignored.
    run_frame(1'b0, 1'b1, 12);
    step();
    chk("final_idle_ready", pix_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
